// File: rtl/core_decode_stage.sv
// RV32I decode stage: IBUF_DEPTH-entry instruction FIFO feeding a registered decode bundle.
// Optional RV32M support is enabled by defining CORE_DECODE_RV32M_EN (adds md_op_o).
module core_decode_stage #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned IBUF_DEPTH = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     in_instr_i,
  input  logic [XLEN-1:0] in_pc_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [3:0]      alu_op_o,
  output logic [1:0]      op_a_sel_o,
  output logic            op_b_sel_o,
  output logic [4:0]      rs1_addr_o,
  output logic [4:0]      rs2_addr_o,
  output logic [4:0]      rd_addr_o,
  output logic            rd_we_o,
  output logic [XLEN-1:0] imm_o,
  output logic [XLEN-1:0] pc_o,
  output logic            illegal_o
`ifdef CORE_DECODE_RV32M_EN
  ,
  output logic            md_op_o
`endif
);

  localparam int unsigned PtrW = (IBUF_DEPTH > 1) ? $clog2(IBUF_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(IBUF_DEPTH + 1);

  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcOp     = 7'b0110011;

  localparam logic [3:0] AluAdd = 4'h0;
  localparam logic [3:0] AluSub = 4'h8;

  localparam logic [1:0] OpASrcRs1  = 2'd0;
  localparam logic [1:0] OpASrcPc   = 2'd1;
  localparam logic [1:0] OpASrcZero = 2'd2;
  localparam logic       OpBSrcRs2  = 1'b0;
  localparam logic       OpBSrcImm  = 1'b1;

  // Instruction FIFO
  logic [31:0]     ibuf_instr_q [IBUF_DEPTH];
  logic [XLEN-1:0] ibuf_pc_q    [IBUF_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            in_ready_q, in_ready_d;
  logic            push, pop;

  // Output register
  logic            out_valid_q;
  logic [3:0]      alu_op_q;
  logic [1:0]      op_a_sel_q;
  logic            op_b_sel_q;
  logic [4:0]      rs1_addr_q, rs2_addr_q, rd_addr_q;
  logic            rd_we_q;
  logic [XLEN-1:0] imm_q, pc_q;
  logic            illegal_q;

  // Decode of the FIFO head
  logic [31:0]     head_instr;
  logic [XLEN-1:0] head_pc;
  logic [6:0]      opcode, funct7;
  logic [2:0]      funct3;
  logic [4:0]      rd_addr;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [3:0]      dec_alu_op;
  logic [1:0]      dec_op_a;
  logic            dec_op_b;
  logic [XLEN-1:0] dec_imm;
  logic            dec_rd_we;
  logic            dec_illegal;
`ifdef CORE_DECODE_RV32M_EN
  logic            dec_md;
  logic            md_op_q;
`endif

  // Ready only reflects free space, so a full FIFO refuses a push even when it pops.
  assign push = in_valid_i & in_ready_q & ~flush_i;
  assign pop  = (count_q != '0) & (~out_valid_q | out_ready_i) & ~flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
    in_ready_d = (count_d != CntW'(IBUF_DEPTH));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      in_ready_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      in_ready_q <= in_ready_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      ibuf_instr_q[wr_ptr_q] <= in_instr_i;
      ibuf_pc_q[wr_ptr_q]    <= in_pc_i;
    end
  end

  assign head_instr = ibuf_instr_q[rd_ptr_q];
  assign head_pc    = ibuf_pc_q[rd_ptr_q];
  assign opcode     = head_instr[6:0];
  assign funct3     = head_instr[14:12];
  assign funct7     = head_instr[31:25];
  assign rd_addr    = head_instr[11:7];

  assign imm_i = {{20{head_instr[31]}}, head_instr[31:20]};
  assign imm_s = {{20{head_instr[31]}}, head_instr[31:25], head_instr[11:7]};
  assign imm_b = {{19{head_instr[31]}}, head_instr[31], head_instr[7], head_instr[30:25],
                  head_instr[11:8], 1'b0};
  assign imm_u = {head_instr[31:12], 12'b0};
  assign imm_j = {{11{head_instr[31]}}, head_instr[31], head_instr[19:12], head_instr[20],
                  head_instr[30:21], 1'b0};

  always_comb begin
    dec_alu_op  = AluAdd;
    dec_op_a    = OpASrcRs1;
    dec_op_b    = OpBSrcImm;
    dec_imm     = '0;
    dec_rd_we   = (rd_addr != 5'd0);
    dec_illegal = 1'b0;
`ifdef CORE_DECODE_RV32M_EN
    dec_md      = 1'b0;
`endif
    unique case (opcode)
      OpcOpImm: begin
        dec_imm    = imm_i;
        // Only SRAI carries funct7[5] into the ALU op.
        dec_alu_op = {head_instr[30] & (funct3 == 3'b101), funct3};
        if ((funct3 == 3'b001 || funct3 == 3'b101) && !(funct7 == 7'h00 || funct7 == 7'h20)) begin
          dec_illegal = 1'b1;
        end
      end
      OpcOp: begin
        dec_op_b = OpBSrcRs2;
        unique case (funct7)
          7'h00: dec_alu_op = {1'b0, funct3};
          7'h20: begin
            dec_alu_op = {1'b1, funct3};
            if (!(funct3 == 3'b000 || funct3 == 3'b101)) dec_illegal = 1'b1;
          end
`ifdef CORE_DECODE_RV32M_EN
          7'h01: begin
            dec_alu_op = {1'b1, funct3};
            dec_md     = 1'b1;
          end
`endif
          default: dec_illegal = 1'b1;
        endcase
      end
      OpcLui: begin
        dec_op_a = OpASrcZero;
        dec_imm  = imm_u;
      end
      OpcAuipc: begin
        dec_op_a = OpASrcPc;
        dec_imm  = imm_u;
      end
      OpcJal: begin
        dec_op_a = OpASrcPc;
        dec_imm  = imm_j;
      end
      OpcJalr, OpcLoad: dec_imm = imm_i;
      OpcStore: begin
        dec_imm   = imm_s;
        dec_rd_we = 1'b0;
      end
      OpcBranch: begin
        dec_op_b   = OpBSrcRs2;
        dec_imm    = imm_b;
        dec_rd_we  = 1'b0;
        dec_alu_op = AluSub;
      end
      default: dec_illegal = 1'b1;
    endcase
    if (head_instr[1:0] != 2'b11) dec_illegal = 1'b1;
    // Illegal instructions still issue, but as a harmless non-writing ADD.
    if (dec_illegal) begin
      dec_alu_op = AluAdd;
      dec_op_a   = OpASrcRs1;
      dec_op_b   = OpBSrcRs2;
      dec_imm    = '0;
      dec_rd_we  = 1'b0;
`ifdef CORE_DECODE_RV32M_EN
      dec_md     = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      alu_op_q    <= '0;
      op_a_sel_q  <= '0;
      op_b_sel_q  <= 1'b0;
      rs1_addr_q  <= '0;
      rs2_addr_q  <= '0;
      rd_addr_q   <= '0;
      rd_we_q     <= 1'b0;
      imm_q       <= '0;
      pc_q        <= '0;
      illegal_q   <= 1'b0;
`ifdef CORE_DECODE_RV32M_EN
      md_op_q     <= 1'b0;
`endif
    end else if (flush_i) begin
      out_valid_q <= 1'b0;
    end else if (pop) begin
      out_valid_q <= 1'b1;
      alu_op_q    <= dec_alu_op;
      op_a_sel_q  <= dec_op_a;
      op_b_sel_q  <= dec_op_b;
      rs1_addr_q  <= head_instr[19:15];
      rs2_addr_q  <= head_instr[24:20];
      rd_addr_q   <= rd_addr;
      rd_we_q     <= dec_rd_we;
      imm_q       <= dec_imm;
      pc_q        <= head_pc;
      illegal_q   <= dec_illegal;
`ifdef CORE_DECODE_RV32M_EN
      md_op_q     <= dec_md;
`endif
    end else if (out_ready_i) begin
      out_valid_q <= 1'b0;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign alu_op_o    = alu_op_q;
  assign op_a_sel_o  = op_a_sel_q;
  assign op_b_sel_o  = op_b_sel_q;
  assign rs1_addr_o  = rs1_addr_q;
  assign rs2_addr_o  = rs2_addr_q;
  assign rd_addr_o   = rd_addr_q;
  assign rd_we_o     = rd_we_q;
  assign imm_o       = imm_q;
  assign pc_o        = pc_q;
  assign illegal_o   = illegal_q;
`ifdef CORE_DECODE_RV32M_EN
  assign md_op_o     = md_op_q;
`endif

endmodule

// File: tb/tb_core_decode_stage.sv
// Self-checking bench for core_decode_stage: directed scenarios plus randomized traffic
// against a transaction-level model (FIFO queue + output slot). Honours CORE_DECODE_RV32M_EN.
module tb_core_decode_stage;

  localparam int unsigned Depth = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  alu_op;
  logic [1:0]  op_a_sel;
  logic        op_b_sel;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic        rd_we;
  logic [31:0] imm, pc;
  logic        illegal;
`ifdef CORE_DECODE_RV32M_EN
  logic        md_op;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Model state
  logic [63:0] m_fifo[$];
  logic        m_out_full = 1'b0;
  logic [63:0] m_out = '0;
  logic        m_ready = 1'b0;

  core_decode_stage #(.XLEN(32), .IBUF_DEPTH(Depth)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_instr_i  (in_instr),
    .in_pc_i     (in_pc),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .alu_op_o    (alu_op),
    .op_a_sel_o  (op_a_sel),
    .op_b_sel_o  (op_b_sel),
    .rs1_addr_o  (rs1_addr),
    .rs2_addr_o  (rs2_addr),
    .rd_addr_o   (rd_addr),
    .rd_we_o     (rd_we),
    .imm_o       (imm),
    .pc_o        (pc),
    .illegal_o   (illegal)
`ifdef CORE_DECODE_RV32M_EN
    ,
    .md_op_o     (md_op)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic obs_md();
`ifdef CORE_DECODE_RV32M_EN
    return md_op;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [90:0] obs_vec();
    return {out_valid, in_ready, alu_op, op_a_sel, op_b_sel, rs1_addr, rs2_addr, rd_addr,
            rd_we, imm, pc, illegal, obs_md()};
  endfunction

  // Reference decode straight from the ISA field rules, using integer arithmetic.
  task automatic ref_decode(input logic [31:0] ins, input logic [31:0] ipc,
                            output logic [88:0] b, output logic [88:0] bm);
    int f3, f7, rd, ival, simm, bimm, jimm;
    logic [31:0] iv;
    logic [3:0]  alu;
    logic [1:0]  a;
    logic        opb, we, ill, md, imm_used;
    f3   = int'(ins[14:12]);
    f7   = int'(ins[31:25]);
    rd   = int'(ins[11:7]);
    ival = int'($signed(ins) >>> 20);
    simm = int'($signed(ins) >>> 25) * 32 + int'(ins[11:7]);
    bimm = int'($signed(ins) >>> 31) * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32
         + int'(ins[11:8]) * 2;
    jimm = int'($signed(ins) >>> 31) * 1048576 + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048
         + int'(ins[30:21]) * 2;
    alu = 4'h0; a = 2'd0; opb = 1'b1; iv = '0; imm_used = 1'b1;
    we = (rd != 0); ill = 1'b0; md = 1'b0;
    case (ins[6:0])
      7'h13: begin
        iv  = ival;
        alu = 4'(f3 + (((f3 == 5) && ins[30]) ? 8 : 0));
        if ((f3 == 1 || f3 == 5) && f7 != 0 && f7 != 32) ill = 1'b1;
      end
      7'h33: begin
        opb = 1'b0; imm_used = 1'b0;
        if (f7 == 0) alu = 4'(f3);
        else if (f7 == 32 && (f3 == 0 || f3 == 5)) alu = 4'(8 + f3);
`ifdef CORE_DECODE_RV32M_EN
        else if (f7 == 1) begin alu = 4'(8 + f3); md = 1'b1; end
`endif
        else ill = 1'b1;
      end
      7'h37: begin a = 2'd2; iv = ins & 32'hFFFF_F000; end
      7'h17: begin a = 2'd1; iv = ins & 32'hFFFF_F000; end
      7'h6F: begin a = 2'd1; iv = jimm; end
      7'h67, 7'h03: iv = ival;
      7'h23: begin iv = simm; we = 1'b0; end
      7'h63: begin opb = 1'b0; iv = bimm; we = 1'b0; alu = 4'h8; end
      default: ill = 1'b1;
    endcase
    if (ins[1:0] != 2'b11) ill = 1'b1;
    if (ill) begin alu = 4'h0; we = 1'b0; md = 1'b0; end
    b  = {alu, a, opb, ins[19:15], ins[24:20], ins[11:7], we, iv, ipc, ill, md};
    bm = {4'hF, {2{!ill}}, !ill, 15'h7FFF, 1'b1, {32{!ill && imm_used}}, {32{1'b1}}, 2'b11};
  endtask

  task automatic get_exp(output logic [90:0] e, output logic [90:0] m);
    logic [88:0] b, bm;
    ref_decode(m_out[63:32], m_out[31:0], b, bm);
    e = {m_out_full, m_ready, b};
    m = {2'b11, m_out_full ? bm : 89'b0};
  endtask

  // Advance the model by one edge using the currently driven inputs, then clock the DUT.
  task automatic tick();
    bit do_push;
    if (rst) begin
      m_fifo.delete(); m_out_full = 1'b0; m_ready = 1'b0;
    end else if (flush) begin
      m_fifo.delete(); m_out_full = 1'b0; m_ready = 1'b1;
    end else begin
      do_push = in_valid && m_ready;
      if (m_fifo.size() > 0 && (!m_out_full || out_ready)) begin
        m_out = m_fifo.pop_front();
        m_out_full = 1'b1;
      end else if (out_ready) begin
        m_out_full = 1'b0;
      end
      if (do_push) m_fifo.push_back({in_instr, in_pc});
      m_ready = (m_fifo.size() < Depth);
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [6:0]  opc, f7;
    r = $urandom;
    case ($urandom_range(0, 9))
      0: opc = 7'h13; 1: opc = 7'h33; 2: opc = 7'h37; 3: opc = 7'h17; 4: opc = 7'h6F;
      5: opc = 7'h67; 6: opc = 7'h03; 7: opc = 7'h23; 8: opc = 7'h63;
      default: opc = r[31:25];
    endcase
    case ($urandom_range(0, 3))
      0: f7 = 7'h00; 1: f7 = 7'h20; 2: f7 = 7'h01;
      default: f7 = 7'($urandom);
    endcase
    return {f7, r[24:7], opc};
  endfunction

  // Push one instruction into an empty pipeline; the bundle is valid after the second edge.
  task automatic issue_one(input logic [31:0] ins, input logic [31:0] ipc);
    out_ready = 1'b1; in_valid = 1'b1; in_instr = ins; in_pc = ipc;
    tick();
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    logic [90:0] e, m;
    rst = 1'b1; flush = 1'b1; in_valid = 1'b1; in_instr = 32'hFFF08293; out_ready = 1'b1;
    tick(); tick();
    n_checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_handshake: in_ready=%b out_valid=%b, want 0/0", in_ready, out_valid);
    end
    n_checks++;
    if (obs_vec()[88:0] !== 89'b0) begin
      n_fail++;
      $display("FAIL reset_bundle: got %h want 0", obs_vec()[88:0]);
    end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    tick();
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready_after: in_ready=%b want 1", in_ready);
    end
    get_exp(e, m);
    n_checks++;
    if ((obs_vec() & m) !== (e & m)) begin
      n_fail++;
      $display("FAIL reset_model: got %h want %h", obs_vec() & m, e & m);
    end
  endtask

  task automatic test_addi();
    issue_one(32'hFFF08293, 32'h0000_0100);
    n_checks++;
    if ({out_valid, alu_op, op_b_sel, imm, rd_addr, rd_we, illegal}
        !== {1'b1, 4'h0, 1'b1, 32'hFFFF_FFFF, 5'd5, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL addi: valid=%b alu=%h opb=%b imm=%h rd=%0d we=%b ill=%b", out_valid, alu_op,
               op_b_sel, imm, rd_addr, rd_we, illegal);
    end
    n_checks++;
    if (pc !== 32'h100 || rs1_addr !== 5'd1 || op_a_sel !== 2'd0) begin
      n_fail++;
      $display("FAIL addi_fields: pc=%h rs1=%0d opa=%0d want 100/1/0", pc, rs1_addr, op_a_sel);
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic [90:0] e, m;
    logic [31:0] issued[$];
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_instr = rand_instr(); in_pc = 32'h200 + 32'(4 * i);
      tick();
    end
    in_instr = rand_instr(); in_pc = 32'h20C;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || pc !== 32'h200) begin
        n_fail++;
        $display("FAIL bp_hold: in_ready=%b out_valid=%b pc=%h want 0/1/200", in_ready,
                 out_valid, pc);
      end
    end
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (out_valid) issued.push_back(pc);
      if (in_valid && m_ready) begin
        tick();
        in_valid = 1'b0;
      end else begin
        tick();
      end
      get_exp(e, m);
      n_checks++;
      if ((obs_vec() & m) !== (e & m)) begin
        n_fail++;
        $display("FAIL bp_model c%0d: got %h want %h", c, obs_vec() & m, e & m);
      end
    end
    in_valid = 1'b0;
    n_checks++;
    if (issued.size() != 4) begin
      n_fail++;
      $display("FAIL bp_count: issued %0d want 4", issued.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (issued[i] !== 32'h200 + 32'(4 * i)) begin
          n_fail++;
          $display("FAIL bp_order[%0d]: pc=%h want %h", i, issued[i], 32'h200 + 32'(4 * i));
        end
      end
    end
  endtask

  task automatic test_stream();
    logic [90:0] e, m;
    int seen, first, last;
    seen = 0; first = -1; last = -1;
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      in_valid = (i < 8); in_instr = rand_instr(); in_pc = 32'h1000 + 32'(4 * i);
      tick();
      get_exp(e, m);
      n_checks++;
      if ((obs_vec() & m) !== (e & m)) begin
        n_fail++;
        $display("FAIL stream_model t%0d: got %h want %h", i, obs_vec() & m, e & m);
      end
      if (out_valid) begin
        n_checks++;
        if (pc !== 32'h1000 + 32'(4 * seen)) begin
          n_fail++;
          $display("FAIL stream_pc: pc=%h want %h", pc, 32'h1000 + 32'(4 * seen));
        end
        if (first < 0) first = i;
        last = i;
        seen++;
      end
    end
    in_valid = 1'b0;
    n_checks++;
    if (seen != 8 || last - first + 1 != 8 || first != 1) begin
      n_fail++;
      $display("FAIL stream_run: seen=%0d first=%0d last=%0d want 8/1/8", seen, first, last);
    end
  endtask

  task automatic test_flush();
    int leaked;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_instr = rand_instr(); in_pc = 32'h300 + 32'(4 * i);
      tick();
    end
    flush = 1'b1; in_instr = 32'h00000013; in_pc = 32'h3FC;
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_edge: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    leaked = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (out_valid) leaked++;
    end
    n_checks++;
    if (leaked != 0) begin
      n_fail++;
      $display("FAIL flush_leak: %0d bundles issued after flush, want 0", leaked);
    end
  endtask

  task automatic test_decode();
    issue_one(32'h00208463, 32'h400);
    n_checks++;
    if ({imm, op_b_sel, rd_we, alu_op, illegal} !== {32'd8, 1'b0, 1'b0, 4'h8, 1'b0}) begin
      n_fail++;
      $display("FAIL beq: imm=%h opb=%b we=%b alu=%h ill=%b want 8/0/0/8/0", imm, op_b_sel,
               rd_we, alu_op, illegal);
    end
    tick();
    issue_one(32'h00000000, 32'h404);
    n_checks++;
    if ({out_valid, illegal, rd_we, alu_op} !== {1'b1, 1'b1, 1'b0, 4'h0}) begin
      n_fail++;
      $display("FAIL zero_instr: valid=%b ill=%b we=%b alu=%h want 1/1/0/0", out_valid, illegal,
               rd_we, alu_op);
    end
    tick();
    issue_one(32'h802081B3, 32'h408);
    n_checks++;
    if ({illegal, rd_we} !== 2'b10) begin
      n_fail++;
      $display("FAIL op_f7_40: ill=%b we=%b want 1/0", illegal, rd_we);
    end
    tick();
    issue_one(32'h022081B3, 32'h40C);
    n_checks++;
`ifdef CORE_DECODE_RV32M_EN
    if ({illegal, alu_op, md_op, op_b_sel, rd_we} !== {1'b0, 4'h8, 1'b1, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL mul: ill=%b alu=%h md=%b opb=%b we=%b want 0/8/1/0/1", illegal, alu_op,
               md_op, op_b_sel, rd_we);
    end
`else
    if ({illegal, rd_we} !== 2'b10) begin
      n_fail++;
      $display("FAIL mul: ill=%b we=%b want 1/0", illegal, rd_we);
    end
`endif
    tick();
  endtask

  task automatic test_random();
    logic [90:0] e, m;
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      in_instr  = rand_instr();
      in_pc     = $urandom & 32'hFFFF_FFFC;
      tick();
      get_exp(e, m);
      n_checks++;
      if ((obs_vec() & m) !== (e & m)) begin
        n_fail++;
        $display("FAIL random_model t%0d: got %h want %h", i, obs_vec() & m, e & m);
      end
    end
    flush = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_addi();
    test_backpressure();
    test_stream();
    test_flush();
    test_decode();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
